systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream edge stage of the systolic PE array. Accepts one N-lane FP32 operand vector per handshake and drives the array's left/top edge with lane i delayed by i array steps. This produces the diagonal wavefront the PE grid needs.
- Emits a step strobe that advances the array.
- After the last vector of a tile, auto-flushes zeros so the wavefront drains, then pulses tile_done.

Parameters:
- N, 4, number of lanes (PE rows or columns fed); N >= 2.
- DW, 32, lane width in bits (IEEE-754 single).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  feeder can accept a vector this cycle.
- in_data  input  N*DW  lane i at bits [i*DW +: DW].
- in_last  input  1  qualifies final vector of the current tile.
- out_data  output  N*DW  skewed edge operands to the PE array, registered.
- step  output  1  registered strobe; the array consumes out_data and advances on a cycle with step=1.
- tile_done  output  1  one-cycle pulse after flush completes.

Behaviour:
- Reset (rst=0, async): state=IDLE; all delay registers, out_data, step and tile_done = 0; flush counter = 0.
- Reset is asynchronous assert and synchronous-to-clk release. Reset mid-STREAM or mid-FLUSH discards all in-flight data; no tile_done is issued.
- States:
  - IDLE: in_ready=1. On accept, go to STREAM, or to FLUSH if in_last=1.
  - STREAM: in_ready=1. On accept with in_last=1, go to FLUSH.
  - FLUSH: in_ready=0, runs for N-1 cycles.
- accept = in_valid & in_ready.
- adv = accept | (state==FLUSH).
- Delay line per lane, advancing only when adv=1:
  - Lane 0 has no extra delay.
  - Lane i has i extra stages.
  - During FLUSH the value pushed into every lane's delay line is 32'h0 (FP32 +0.0, neutral for the MAC).
- Registered outputs:
  - On adv=1, the next cycle has step=1, and out_data lane i = the lane-i input from i advances earlier (0 if none since reset or tile start).
  - On adv=0, the next cycle has step=0 and out_data holds its value.
- Latency: vector k lane i appears on out_data 1+i step cycles after acceptance (i cycles later than lane 0, counted in adv cycles).
- Stalls: in STREAM with in_valid=0, adv=0. Skew relationships are preserved across bubbles because delays count steps, not cycles.
- FLUSH: counter runs 0..N-2, adv=1 each cycle. On the final flush cycle the next state is IDLE and tile_done=1 is registered. tile_done therefore coincides with the step cycle carrying the last nonzero lane N-1 data.
- Single-vector tile (in_last on first beat): IDLE goes directly to FLUSH; same N-1 flush cycles.
- in_valid during FLUSH: not accepted (in_ready=0); the upstream source must hold the data.
- After FLUSH, all delay registers are zero, so the next tile starts clean.
- No arithmetic on data; values pass bit-exact.

Optional Feature:
- Macro: SKEW_FEEDER_PERF_EN.
- With the macro defined:
  - Extra output stall_cnt, 16 bits: counts STREAM cycles with in_valid=0, saturating at 16'hFFFF.
  - Cleared by reset and on entry to STREAM from IDLE.
  - Holds its value through FLUSH and IDLE.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 mid-FLUSH -> out_data=0, step=0, tile_done=0 immediately (async); after release, state IDLE, in_ready=1.
- N=4, tile of 4 back-to-back vectors, all lanes = 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000 in turn, last on beat 4:
  - Lane 0 shows 40000000..41800000 on step cycles 1-4.
  - Lane 3 shows 0,0,0,40000000,40800000,41000000,41800000 on step cycles 1-7.
  - tile_done pulses with step cycle 7.
- Bubbles: same tile with in_valid=0 for 2 cycles between beats 2 and 3 -> step=0 on those cycles, out_data held; the lane sequences per step are identical to the previous scenario.
- Single-vector tile: in_data lanes = 32'h3F800000, in_last=1 -> lane i = 3F800000 on step cycle 1+i only, else 0; in_ready=0 for 3 cycles; tile_done on step cycle 4.
- Back-to-back tiles: tile B's in_valid held high through tile A's FLUSH -> tile B accepted on the first IDLE cycle; no tile-A data leaks into tile-B lanes.
- With SKEW_FEEDER_PERF_EN: 5 bubble cycles in STREAM -> stall_cnt=5 after tile_done; new tile resets it to 0.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic PE array: lane i is delayed by i array steps, then zeros are
// flushed in after the last vector of a tile. Optional stall counter under SKEW_FEEDER_PERF_EN.
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic [N*DW-1:0] out_data,
  output logic            step,
`ifdef SKEW_FEEDER_PERF_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            tile_done
);

  localparam int CW = (N > 2) ? $clog2(N - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic            accept;
  logic            adv;
  logic            flush_end;
  logic [N*DW-1:0] push_data;
  logic [N*DW-1:0] taps;
  logic [N*DW-1:0] out_data_q;
  logic            step_q;
  logic            tile_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = 1'b0;
    accept      = 1'b0;
    flush_end   = 1'b0;
    case (state_q)
      S_IDLE, S_STREAM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_d     = in_last ? S_FLUSH : S_STREAM;
          flush_cnt_d = '0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == CW'(N - 2)) begin
          flush_end   = 1'b1;
          state_d     = S_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Delays count array steps, not clock cycles, so bubbles keep the skew intact.
  assign adv       = accept | (state_q == S_FLUSH);
  assign push_data = (state_q == S_FLUSH) ? '0 : in_data;

  assign taps[0 +: DW] = push_data[0 +: DW];

  for (genvar i = 1; i < N; i++) begin : g_dly
    logic [DW-1:0] sr_q [i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < i; j++) sr_q[j] <= '0;
      end else if (adv) begin
        sr_q[0] <= push_data[i*DW +: DW];
        for (int j = 1; j < i; j++) sr_q[j] <= sr_q[j-1];
      end
    end

    assign taps[i*DW +: DW] = sr_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_q  <= '0;
      step_q      <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      step_q      <= adv;
      tile_done_q <= flush_end;
      if (adv) out_data_q <= taps;
    end
  end

  assign out_data  = out_data_q;
  assign step      = step_q;
  assign tile_done = tile_done_q;

`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && accept && !in_last) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_STREAM) && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: a step-history model predicts each edge vector.
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int W  = N * DW;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last  = 1'b0;
  logic [W-1:0] in_data  = '0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         step;
  logic         tile_done;
`ifdef SKEW_FEEDER_PERF_EN
  logic [15:0]  stall_cnt;
`endif

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_data (out_data),
    .step     (step),
`ifdef SKEW_FEEDER_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         done;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  int           errors = 0;
  int           checks = 0;
  int           mstate = 0;      // 0 idle, 1 stream, 2 flush
  int           flush_left = 0;
  bit           m_acc = 1'b0;
  int           stall_m = 0;
  logic [W-1:0] last_exp = '0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Lane i of the edge is whatever was pushed i steps ago, or zero if nothing was.
  function automatic logic [W-1:0] expected_edge();
    logic [W-1:0] r = '0;
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      if (hist.size() > i) begin
        v = hist[hist.size() - 1 - i];
        r[i*DW +: DW] = v[i*DW +: DW];
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstate = 0;
      flush_left = 0;
      m_acc = 1'b0;
      stall_m = 0;
      exp_q.delete();
      hist.delete();
    end else begin
      bit   rdy;
      bit   adv;
      exp_t e;
      rdy   = (mstate != 2);
      m_acc = in_valid && rdy;
      adv   = m_acc || (mstate == 2);
      if (mstate == 1 && !in_valid && stall_m < 65535) stall_m++;
      if (adv) begin
        hist.push_back(m_acc ? in_data : '0);
        if (hist.size() > N) void'(hist.pop_front());
        e.data = expected_edge();
        e.done = 1'b0;
        if (mstate == 2) begin
          flush_left--;
          if (flush_left == 0) begin
            e.done = 1'b1;
            mstate = 0;
          end
        end else begin
          if (mstate == 0 && !in_last) stall_m = 0;
          if (in_last) begin
            mstate = 2;
            flush_left = N - 1;
          end else begin
            mstate = 1;
          end
        end
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      last_exp = '0;
    end else begin
      exp_t e;
      check("in_ready", W'(in_ready), W'(mstate != 2));
      if (step) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step: got step=1 expected no step at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("edge_data", out_data, e.data);
          check("tile_done", W'(tile_done), W'(e.done));
          last_exp = e.data;
        end
      end else begin
        check("hold_data", out_data, last_exp);
        check("done_without_step", W'(tile_done), '0);
      end
`ifdef SKEW_FEEDER_PERF_EN
      check("stall_cnt", W'(stall_cnt), W'(stall_m));
`endif
    end
  end

  function automatic logic [W-1:0] bcast(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom();
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input logic last, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 200);
    if (!m_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_out_data", out_data, '0);
    check("rst_step", W'(step), '0);
    check("rst_tile_done", W'(tile_done), '0);
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Four back-to-back vectors
    send(bcast(32'h40000000), 1'b0, 0);
    send(bcast(32'h40800000), 1'b0, 0);
    send(bcast(32'h41000000), 1'b0, 0);
    send(bcast(32'h41800000), 1'b1, 0);
    drain();

    // Same tile with a two-cycle bubble between beats 2 and 3
    send(bcast(32'h40000000), 1'b0, 0);
    send(bcast(32'h40800000), 1'b0, 0);
    send(bcast(32'h41000000), 1'b0, 2);
    send(bcast(32'h41800000), 1'b1, 0);
    drain();

    // Single-vector tile
    send(bcast(32'h3F800000), 1'b1, 0);
    drain();

    // Tile B presented while tile A flushes
    send(rand_vec(), 1'b0, 0);
    send(rand_vec(), 1'b0, 0);
    send(rand_vec(), 1'b1, 0);
    send(rand_vec(), 1'b0, 0);
    send(rand_vec(), 1'b1, 0);
    drain();

    // Five stall cycles inside one tile
    send(rand_vec(), 1'b0, 0);
    send(rand_vec(), 1'b0, 5);
    send(rand_vec(), 1'b1, 0);
    drain();

    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send(rand_vec(), (k == len - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    // Reset in the middle of a flush
    send(bcast(32'h3F800000), 1'b0, 0);
    send(bcast(32'h40400000), 1'b1, 0);
    #2 rst = 1'b0;
    #1;
    check("midflush_out_data", out_data, '0);
    check("midflush_step", W'(step), '0);
    check("midflush_tile_done", W'(tile_done), '0);
    check("midflush_in_ready", W'(in_ready), W'(1'b1));
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(rand_vec(), 1'b0, 0);
    send(rand_vec(), 1'b1, 1);
    drain();

    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
